wordcell: RTL and testbench



---
 rtl/wordcell_if.sv | 27 ++
 rtl/wordcell.sv | 34 +++
 tb/tb_wordcell.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wordcell_if.sv
// Row-side bus of one storage word: select, read/write control, write data, read data and debug tap.
// The column logic is the master; the word itself is the slave.
interface wordcell_if #(
    parameter int WIDTH = 8
);
    logic             op;
    logic             sel_x;
    logic [WIDTH-1:0] in_bus;
    logic [WIDTH-1:0] out_bus;
    logic [WIDTH-1:0] stored_value;

    modport master (
        output op,
        output sel_x,
        output in_bus,
        input  out_bus,
        input  stored_value
    );

    modport slave (
        input  op,
        input  sel_x,
        input  in_bus,
        output out_bus,
        output stored_value
    );
endinterface

// File: rtl/wordcell.sv
// One addressable memory word of WIDTH bitcells; writes land 1 clk after sel_x&op, reads are combinational.
// No backpressure: every selected access completes in its own cycle.
module wordcell #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    wordcell_if.slave bus
);
    logic             we;
    logic             re;
    logic [WIDTH-1:0] cells;

    assign we = bus.sel_x & bus.op;
    assign re = bus.sel_x & ~bus.op;

    // Each bit is its own cell; reset outranks a coincident write.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        logic q;

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= 1'b0;
            end else if (we) begin
                q <= bus.in_bus[g];
            end
        end

        assign cells[g] = q;
    end

    assign bus.stored_value = cells;
    assign bus.out_bus      = re ? cells : '0;
endmodule

// File: tb/tb_wordcell.sv
// Directed table-driven bench for wordcell plus a hand-written between-edge control sequence.
module tb_wordcell;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wordcell_if #(.WIDTH(W)) bus ();

    wordcell #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         rst;
        logic         op;
        logic         sel;
        logic [W-1:0] din;
        logic [W-1:0] exp_out;   // out_bus with inputs applied, before the edge
        logic [W-1:0] exp_st;    // stored_value just after the edge
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_no_x(input string name);
        checks++;
        if ($isunknown({bus.out_bus, bus.stored_value})) begin
            failures++;
            $display("FAIL %s: X on outputs out=%b st=%b", name, bus.out_bus, bus.stored_value);
        end
    endtask

    vec_t vecs[17];

    initial begin
        checks   = 0;
        failures = 0;
        rst        = 1'b0;
        bus.op     = 1'b0;
        bus.sel_x  = 1'b0;
        bus.in_bus = '0;

        //          rst   op    sel   din    out    st
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h55, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h55, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h55, 8'h00, 8'h55};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h55, 8'h55};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h55};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'hCC, 8'h00, 8'hCC};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hCC, 8'hCC};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 8'hA5, 8'h00, 8'hA5};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5, 8'hA5};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 8'hA5};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hA5, 8'h00};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            bus.op     = vecs[i].op;
            bus.sel_x  = vecs[i].sel;
            bus.in_bus = vecs[i].din;
            #1;
            check($sformatf("v%0d_out", i), bus.out_bus, vecs[i].exp_out);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_st", i), bus.stored_value, vecs[i].exp_st);
            check_no_x($sformatf("v%0d_nox", i));
        end

        // Write 0x81, then wiggle control between edges: only out_bus may move.
        @(negedge clk);
        rst = 1'b0; bus.op = 1'b1; bus.sel_x = 1'b1; bus.in_bus = 8'h81;
        @(posedge clk);
        #1;
        check("seq_wr_st", bus.stored_value, 8'h81);
        check("seq_wr_out", bus.out_bus, 8'h00);
        bus.op = 1'b0; bus.in_bus = 8'h7E;
        #1;
        check("seq_rd_out", bus.out_bus, 8'h81);
        bus.sel_x = 1'b0;
        #1;
        check("seq_desel_out", bus.out_bus, 8'h00);
        bus.sel_x = 1'b1; bus.op = 1'b1;
        #1;
        check("seq_wr_pending_out", bus.out_bus, 8'h00);
        check("seq_wr_pending_st", bus.stored_value, 8'h81);
        bus.op = 1'b0;
        #1;
        check("seq_rd_again_out", bus.out_bus, 8'h81);
        @(posedge clk);
        #1;
        check("seq_hold_st", bus.stored_value, 8'h81);

        // Back-to-back writes then immediate read-after-write.
        @(negedge clk);
        bus.op = 1'b1; bus.sel_x = 1'b1; bus.in_bus = 8'h0F;
        @(negedge clk);
        bus.in_bus = 8'hF0;
        @(negedge clk);
        bus.op = 1'b0; bus.in_bus = 8'h00;
        #1;
        check("b2b_st", bus.stored_value, 8'hF0);
        check("b2b_out", bus.out_bus, 8'hF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
